led_scan_capture: RTL and testbench

Receive-side counterpart of the LED-matrix row-scan output driven on GPIO_1 by the DE1_SoC top level. It watches the multiplexed scan signals (row address, enable, red/green column lines), reconstructs the full 16x16 two-colour frame into a double-buffered memory, and checks scan order. It also exposes a registered row-read port, frame strobe/counter and a sticky sequence-error flag for self-checking benches and on-board loopback of the cellular-automaton display.

---
 rtl/led_scan_capture.sv | 162 ++++++++++++++++
 tb/tb_led_scan_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_capture.sv
// rtl/led_scan_capture.sv - LED-matrix row-scan receiver: debounced row capture, frame rebuild, scan-order check
module led_scan_capture #(
  parameter int SETTLE = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [3:0]  scan_row,
  input  logic [15:0] scan_red,
  input  logic [15:0] scan_grn,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_red,
  output logic [15:0] rd_grn,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        seq_err,
  output logic        capturing
);

  localparam logic [3:0] SETTLE_W  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  expected_q, expected_d;
  logic [3:0]  last_q, last_d;
  logic        err_q, err_d;
  logic        wr_en, pub_d;

  logic        prev_en_q;
  logic [3:0]  prev_row_q;
  logic [15:0] prev_red_q, prev_grn_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        pub_q, fv_q;
  logic [7:0]  count_q;
  logic [15:0] rd_red_q, rd_grn_q;
  logic [15:0] sh_red_q [16];
  logic [15:0] sh_grn_q [16];
  logic [15:0] dp_red_q [16];
  logic [15:0] dp_grn_q [16];

  // A row only counts as stable once it was already enabled on the previous edge,
  // so re-enabling after a blank restarts the settle window.
  logic match, accept;
  assign match  = scan_en && prev_en_q && (scan_row == prev_row_q) &&
                  (scan_red == prev_red_q) && (scan_grn == prev_grn_q);
  assign accept = match && (cnt_q == SETTLE_M1);

  always_comb begin
    cnt_d = 4'd0;
    if (match) cnt_d = (cnt_q == SETTLE_W) ? cnt_q : cnt_q + 4'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= 4'd0;
      last_q     <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    last_d     = last_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    pub_d      = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (scan_row == 4'd0) begin
            state_d    = CAPTURE;
            expected_d = 4'd1;
            last_d     = 4'd0;
            wr_en      = 1'b1;
          end
        end
        default: begin
          if (scan_row == expected_q) begin
            wr_en      = 1'b1;
            expected_d = scan_row + 4'd1;
            last_d     = scan_row;
            pub_d      = (scan_row == 4'd15);
          end else if (scan_row == last_q) begin
            wr_en = 1'b1;
          end else begin
            // Out-of-order row: a fresh row 0 restarts the frame in place.
            err_d = 1'b1;
            if (scan_row == 4'd0) begin
              expected_d = 4'd1;
              last_d     = 4'd0;
              wr_en      = 1'b1;
            end else begin
              state_d = HUNT;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    capturing = (state_q == CAPTURE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prev_en_q  <= 1'b0;
      prev_row_q <= 4'd0;
      prev_red_q <= 16'd0;
      prev_grn_q <= 16'd0;
      cnt_q      <= 4'd0;
      pub_q      <= 1'b0;
      fv_q       <= 1'b0;
      count_q    <= 8'd0;
      rd_red_q   <= 16'd0;
      rd_grn_q   <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        sh_red_q[i] <= 16'd0;
        sh_grn_q[i] <= 16'd0;
        dp_red_q[i] <= 16'd0;
        dp_grn_q[i] <= 16'd0;
      end
    end else begin
      prev_en_q  <= scan_en;
      prev_row_q <= scan_row;
      prev_red_q <= scan_red;
      prev_grn_q <= scan_grn;
      cnt_q      <= cnt_d;
      pub_q      <= pub_d;
      fv_q       <= pub_q;
      if (wr_en) begin
        sh_red_q[scan_row] <= scan_red;
        sh_grn_q[scan_row] <= scan_grn;
      end
      if (pub_q) begin
        count_q <= count_q + 8'd1;
        for (int i = 0; i < 16; i++) begin
          dp_red_q[i] <= sh_red_q[i];
          dp_grn_q[i] <= sh_grn_q[i];
        end
      end
      rd_red_q <= dp_red_q[rd_row];
      rd_grn_q <= dp_grn_q[rd_row];
    end
  end

  assign rd_red      = rd_red_q;
  assign rd_grn      = rd_grn_q;
  assign frame_valid = fv_q;
  assign frame_count = count_q;
  assign seq_err     = err_q;

endmodule

// File: tb/tb_led_scan_capture.sv
// tb/tb_led_scan_capture.sv - directed and randomized row-scan sequences against a transaction-level frame model
module tb_led_scan_capture;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [3:0]  scan_row;
  logic [15:0] scan_red, scan_grn;
  logic [3:0]  rd_row;
  logic [15:0] rd_red, rd_grn;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        seq_err, capturing;

  led_scan_capture #(.SETTLE(SETTLE)) dut (
    .CLOCK_50(clk), .reset(reset), .scan_en(scan_en), .scan_row(scan_row),
    .scan_red(scan_red), .scan_grn(scan_grn), .rd_row(rd_row),
    .rd_red(rd_red), .rd_grn(rd_grn), .frame_valid(frame_valid),
    .frame_count(frame_count), .seq_err(seq_err), .capturing(capturing)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int fv_seen  = 0;

  always @(negedge clk) if (frame_valid === 1'b1) fv_seen++;

  // Frame-level reference: a presentation held long enough is one accepted row.
  bit          m_cap;
  int          m_exp, m_last;
  bit          m_err;
  int          m_frames, m_pulses;
  logic [15:0] m_sh_r [16], m_sh_g [16], m_dp_r [16], m_dp_g [16];

  task automatic model_reset();
    m_cap = 0; m_exp = 0; m_last = 0; m_err = 0; m_frames = 0;
    for (int i = 0; i < 16; i++) begin
      m_sh_r[i] = 0; m_sh_g[i] = 0; m_dp_r[i] = 0; m_dp_g[i] = 0;
    end
  endtask

  task automatic model_accept(input int row, input logic [15:0] r, input logic [15:0] g);
    if (!m_cap) begin
      if (row == 0) begin
        m_cap = 1; m_exp = 1; m_last = 0; m_sh_r[0] = r; m_sh_g[0] = g;
      end
    end else if (row == m_exp) begin
      m_sh_r[row] = r; m_sh_g[row] = g;
      m_last = row; m_exp = (row + 1) % 16;
      if (row == 15) begin
        m_dp_r = m_sh_r; m_dp_g = m_sh_g;
        m_frames++; m_pulses++;
      end
    end else if (row == m_last) begin
      m_sh_r[row] = r; m_sh_g[row] = g;
    end else begin
      m_err = 1;
      if (row == 0) begin
        m_exp = 1; m_last = 0; m_sh_r[0] = r; m_sh_g[0] = g;
      end else begin
        m_cap = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int row, input logic [15:0] r, input logic [15:0] g, input int hold);
    @(negedge clk);
    scan_en = 1'b1; scan_row = 4'(row); scan_red = r; scan_grn = g;
    repeat (hold) @(posedge clk);
    if (hold >= SETTLE + 1) model_accept(row, r, g);
  endtask

  task automatic blank(input int n);
    @(negedge clk);
    scan_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; scan_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_all(input string tag);
    blank(3);
    @(negedge clk);
    chk({tag, " frame_count"}, 32'(frame_count), 32'(m_frames % 256));
    chk({tag, " seq_err"}, 32'(seq_err), 32'(m_err));
    chk({tag, " capturing"}, 32'(capturing), 32'(m_cap));
    chk({tag, " pulses"}, 32'(fv_seen), 32'(m_pulses));
    for (int r = 0; r < 16; r++) begin
      @(negedge clk); rd_row = 4'(r);
      @(negedge clk);
      chk($sformatf("%s rd_red[%0d]", tag, r), 32'(rd_red), 32'(m_dp_r[r]));
      chk($sformatf("%s rd_grn[%0d]", tag, r), 32'(rd_grn), 32'(m_dp_g[r]));
    end
  endtask

  initial begin
    logic [15:0] rr, gg;
    int pulses0, row, hold;
    reset = 1'b1; scan_en = 1'b0; scan_row = 0; scan_red = 0; scan_grn = 0; rd_row = 0;
    m_pulses = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rd_red", 32'(rd_red), 0);
    chk("reset frame_valid", 32'(frame_valid), 0);
    chk("reset frame_count", 32'(frame_count), 0);
    chk("reset seq_err", 32'(seq_err), 0);
    chk("reset capturing", 32'(capturing), 0);
    reset = 1'b0;

    // Clean frame with one-hot red / inverted green
    for (int n = 0; n < 16; n++) begin
      rr = 16'h0001 << n;
      present(n, rr, ~rr, 3);
    end
    check_all("clean");
    @(negedge clk); rd_row = 4'd5;
    @(negedge clk);
    chk("clean row5 red", 32'(rd_red), 32'h0020);
    chk("clean row5 grn", 32'(rd_grn), 32'hFFDF);
    chk("clean count", 32'(frame_count), 1);

    // Glitch: row 3 too short, row 4 lands out of order
    for (int n = 0; n < 3; n++) present(n, 16'($urandom), 16'($urandom), 3);
    present(3, 16'h3333, 16'h3333, 2);
    present(4, 16'h4444, 16'h4444, 3);
    check_all("glitch");
    chk("glitch seq_err", 32'(seq_err), 1);
    chk("glitch hunt", 32'(capturing), 0);

    // Blanking between rows, each row shown twice with new data (row 15 unchanged)
    do_reset();
    for (int n = 0; n < 16; n++) begin
      rr = 16'($urandom); gg = 16'($urandom);
      present(n, rr, gg, 3);
      blank(5);
      if (n != 15) begin rr = 16'($urandom); gg = 16'($urandom); end
      present(n, rr, gg, 3);
      blank(5);
    end
    check_all("blank");

    // Start mid-scan
    do_reset();
    for (int n = 7; n < 16; n++) present(n, 16'($urandom), 16'($urandom), 3);
    for (int n = 0; n < 16; n++) present(n, 16'($urandom), 16'($urandom), 3);
    check_all("midscan");

    // 256 frames wrap the counter back to zero
    do_reset();
    pulses0 = fv_seen;
    for (int f = 0; f < 256; f++)
      for (int n = 0; n < 16; n++) present(n, 16'($urandom), 16'($urandom), 3);
    check_all("wrap");
    chk("wrap count zero", 32'(frame_count), 0);
    chk("wrap pulses", 32'(fv_seen - pulses0), 256);

    // Random mix of in-order, stray, short and repeated rows
    for (int k = 0; k < 400; k++) begin
      row  = ($urandom_range(0, 3) != 0) ? (m_cap ? m_exp : 0) : int'($urandom_range(0, 15));
      hold = int'($urandom_range(2, 4));
      present(row, 16'($urandom), 16'($urandom), hold);
      if ($urandom_range(0, 3) == 0) blank(int'($urandom_range(1, 4)));
    end
    check_all("random");

    // Reset on the publish edge after row 15 is accepted
    do_reset();
    for (int n = 0; n < 15; n++) present(n, 16'($urandom), 16'($urandom), 3);
    @(negedge clk);
    scan_en = 1'b1; scan_row = 4'd15; scan_red = 16'hF00F; scan_grn = 16'h0FF0;
    repeat (SETTLE + 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; scan_en = 1'b0;
    pulses0 = fv_seen;
    @(posedge clk);
    #1;
    chk("rst15 frame_valid", 32'(frame_valid), 0);
    chk("rst15 frame_count", 32'(frame_count), 0);
    chk("rst15 capturing", 32'(capturing), 0);
    chk("rst15 rd_red", 32'(rd_red), 0);
    chk("rst15 rd_grn", 32'(rd_grn), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("rst15");
    chk("rst15 no pulse", 32'(fv_seen - pulses0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
